// File: rtl/sdram_port_arbiter.sv
// Multi-channel arbiter for the SDRAM Avalon-MM port: ch0 fixed priority, others round-robin,
// locked bursts, pipelined reads with a tag FIFO that steers read data back to its channel.
module sdram_port_arbiter #(
    parameter int NCH       = 3,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 32,
    parameter int BLEN_W    = 5,
    parameter int TAG_DEPTH = 8
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic [NCH-1:0]             req_read,
    input  logic [NCH-1:0]             req_write,
    input  logic [NCH*ADDR_W-1:0]      req_addr,
    input  logic [NCH*BLEN_W-1:0]      req_blen,
    input  logic [NCH*DATA_W-1:0]      req_wdata,
    input  logic [NCH*(DATA_W/8)-1:0]  req_byteen_n,
    output logic [NCH-1:0]             grant,
    output logic [NCH-1:0]             beat_ack,
    output logic [DATA_W-1:0]          rd_data,
    output logic [NCH-1:0]             rd_valid,
    output logic                       tag_err,
    output logic [ADDR_W-1:0]          mem_address,
    output logic                       mem_read_n,
    output logic                       mem_write_n,
    output logic [DATA_W-1:0]          mem_writedata,
    output logic [DATA_W/8-1:0]        mem_byteen_n,
    input  logic                       mem_wait,
    input  logic [DATA_W-1:0]          mem_readdata,
    input  logic                       mem_rvalid
);
    localparam int BE_W = DATA_W / 8;
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TP_W = $clog2(TAG_DEPTH);
    localparam int TC_W = TP_W + 1;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_t;

    state_t              state_q, state_d;
    logic [NCH-1:0]      grant_q, grant_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLEN_W-1:0]   cnt_q, cnt_d;
    logic [TP_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [TP_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [TC_W-1:0]     tcnt_q, tcnt_d;
    logic                tag_err_q, tag_err_d;
    logic [CH_W-1:0]     tag_mem_q [TAG_DEPTH];

    logic [NCH-1:0]      req_any;
    logic                win_vld;
    logic [CH_W-1:0]     win_ch;
    logic [BLEN_W-1:0]   win_blen;
    logic                fifo_full;
    logic                accept;
    logic                push;
    logic                pop;

    assign req_any   = req_read | req_write;
    assign win_blen  = req_blen[win_ch*BLEN_W +: BLEN_W];
    assign fifo_full = (tcnt_q == TC_W'(TAG_DEPTH));
    assign accept    = ((state_q == RD_BURST && !fifo_full) || state_q == WR_BURST) && !mem_wait;
    assign push      = accept && (state_q == RD_BURST);
    assign pop       = mem_rvalid && (tcnt_q != '0);

    assign grant         = grant_q;
    assign beat_ack      = accept ? grant_q : '0;
    assign tag_err       = tag_err_q;
    assign mem_address   = addr_q;
    // A full tag FIFO holds off read issue so every return still has a slot.
    assign mem_read_n    = !(state_q == RD_BURST && !fifo_full);
    assign mem_write_n   = (state_q != WR_BURST);
    assign mem_writedata = (state_q == WR_BURST) ? req_wdata[ch_q*DATA_W +: DATA_W] : '0;
    assign mem_byteen_n  = (state_q == WR_BURST) ? req_byteen_n[ch_q*BE_W +: BE_W] : '1;
    assign rd_data       = mem_readdata;
    assign rd_valid      = pop ? (NCH'(1) << tag_mem_q[rd_ptr_q]) : '0;

    // ch0 first, then the first requester at or after rr_q among 1..NCH-1.
    always_comb begin
        int idx;
        idx     = 0;
        win_vld = 1'b0;
        win_ch  = '0;
        if (req_any[0]) begin
            win_vld = 1'b1;
        end else begin
            for (int k = 0; k < NCH - 1; k++) begin
                idx = int'(rr_q) + k;
                if (idx >= NCH) idx = idx - (NCH - 1);
                if (!win_vld && req_any[idx]) begin
                    win_vld = 1'b1;
                    win_ch  = CH_W'(idx);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        tcnt_d    = tcnt_q;
        tag_err_d = tag_err_q | (mem_rvalid && tcnt_q == '0);

        if (state_q == IDLE) begin
            if (win_vld) begin
                state_d = req_read[win_ch] ? RD_BURST : WR_BURST;
                grant_d = NCH'(1) << win_ch;
                ch_d    = win_ch;
                addr_d  = req_addr[win_ch*ADDR_W +: ADDR_W];
                cnt_d   = (win_blen == '0) ? BLEN_W'(1) : win_blen;
                if (win_ch != '0)
                    rr_d = (win_ch == CH_W'(NCH - 1)) ? CH_W'(1) : win_ch + CH_W'(1);
            end
        end else if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - BLEN_W'(1);
            if (cnt_q == BLEN_W'(1)) begin
                state_d = IDLE;
                grant_d = '0;
            end
        end

        if (push) wr_ptr_d = wr_ptr_q + TP_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + TP_W'(1);
        tcnt_d = tcnt_q + TC_W'(push) - TC_W'(pop);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ch_q      <= '0;
            rr_q      <= CH_W'(1);
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tcnt_q    <= '0;
            tag_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ch_q      <= ch_d;
            rr_q      <= rr_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            tcnt_q    <= tcnt_d;
            tag_err_q <= tag_err_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= ch_q;
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: arbitration order, bursts, tag FIFO back-pressure,
// read-return steering, tag_err and asynchronous reset.
module tb_sdram_port_arbiter;
    localparam int NCH = 3, ADDR_W = 25, DATA_W = 32, BLEN_W = 5, TAG_DEPTH = 8, BE_W = 4;

    logic                   Clk, Reset_n;
    logic [NCH-1:0]         req_read, req_write;
    logic [NCH*ADDR_W-1:0]  req_addr;
    logic [NCH*BLEN_W-1:0]  req_blen;
    logic [NCH*DATA_W-1:0]  req_wdata;
    logic [NCH*BE_W-1:0]    req_byteen_n;
    logic [NCH-1:0]         grant, beat_ack, rd_valid;
    logic [DATA_W-1:0]      rd_data, mem_writedata, mem_readdata;
    logic                   tag_err, mem_read_n, mem_write_n, mem_wait, mem_rvalid;
    logic [ADDR_W-1:0]      mem_address;
    logic [BE_W-1:0]        mem_byteen_n;

    int n_cmp = 0;
    int n_err = 0;

    sdram_port_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLEN_W(BLEN_W),
                         .TAG_DEPTH(TAG_DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_blen(req_blen), .req_wdata(req_wdata),
        .req_byteen_n(req_byteen_n), .grant(grant), .beat_ack(beat_ack), .rd_data(rd_data),
        .rd_valid(rd_valid), .tag_err(tag_err), .mem_address(mem_address),
        .mem_read_n(mem_read_n), .mem_write_n(mem_write_n), .mem_writedata(mem_writedata),
        .mem_byteen_n(mem_byteen_n), .mem_wait(mem_wait), .mem_readdata(mem_readdata),
        .mem_rvalid(mem_rvalid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [ADDR_W-1:0] a, input logic [BLEN_W-1:0] bl,
                          input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
        req_addr[ch*ADDR_W +: ADDR_W]   = a;
        req_blen[ch*BLEN_W +: BLEN_W]   = bl;
        req_wdata[ch*DATA_W +: DATA_W]  = wd;
        req_byteen_n[ch*BE_W +: BE_W]   = be;
    endtask

    logic [NCH-1:0]    t2_exp [4] = '{3'b100, 3'b010, 3'b100, 3'b010};
    logic [NCH-1:0]    t5_exp [4] = '{3'b001, 3'b001, 3'b010, 3'b010};
    logic [ADDR_W-1:0] exp_addr;
    logic              pv [3];
    logic              newv;
    int                n_acc, outst, hits, pops, na, nr;

    initial begin
        Reset_n = 1'b1; req_read = '0; req_write = '0; req_addr = '0; req_blen = '0;
        req_wdata = '0; req_byteen_n = '1; mem_wait = 1'b0; mem_readdata = '0; mem_rvalid = 1'b0;
        #2 Reset_n = 1'b0;
        tick(); tick();
        chk("rst_grant", grant, 0);
        chk("rst_beat_ack", beat_ack, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_tag_err", tag_err, 0);
        chk("rst_read_n", mem_read_n, 1);
        chk("rst_write_n", mem_write_n, 1);
        chk("rst_address", mem_address, 0);
        chk("rst_byteen_n", mem_byteen_n, 4'hF);
        @(negedge Clk) Reset_n = 1'b1;

        // Single read burst on ch1, then its four returns.
        set_ch(1, 25'h100, 5'd4, 32'h0, 4'hF);
        req_read = 3'b010;
        tick();
        chk("t1_grant", grant, 3'b010);
        req_read = '0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_addr", mem_address, 25'h100 + k);
            chk("t1_ack", beat_ack, 3'b010);
            chk("t1_read_n", mem_read_n, 0);
            tick();
        end
        chk("t1_end_grant", grant, 0);
        chk("t1_end_read_n", mem_read_n, 1);
        for (int k = 0; k < 4; k++) begin
            mem_rvalid = 1'b1; mem_readdata = 32'hA000_0000 + k;
            #1;
            chk("t1_rd_valid", rd_valid, 3'b010);
            chk("t1_rd_data", rd_data, 32'hA000_0000 + k);
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("t1_rd_valid_off", rd_valid, 0);
        chk("t1_tag_err", tag_err, 0);

        // Round-robin between ch1/ch2 write bursts of one beat, ch0 cutting in.
        set_ch(1, 25'h300, 5'd1, 32'h11, 4'h0);
        set_ch(2, 25'h400, 5'd1, 32'h22, 4'h0);
        req_write = 3'b110;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_grant", grant, t2_exp[i]);
            chk("t2_write_n", mem_write_n, 0);
            chk("t2_ack", beat_ack, t2_exp[i]);
            if (i == 3) begin
                set_ch(0, 25'h500, 5'd0, 32'h33, 4'h0);
                req_write[0] = 1'b1;
            end
            tick();
            chk("t2_idle_grant", grant, 0);
        end
        tick();
        chk("t2_ch0_cut_in", grant, 3'b001);
        req_write[0] = 1'b0;
        tick();
        chk("t2_ch0_done", grant, 0);
        tick();
        chk("t2_rr_kept", grant, 3'b100);
        req_write = '0;
        tick();
        chk("t2_final_idle", grant, 0);

        // ch2 8-beat write across the address wrap with mem_wait toggling; ch0 waits.
        set_ch(2, 25'h1FF_FFFE, 5'd8, 32'hCAFE_F00D, 4'b0101);
        req_write = 3'b100;
        tick();
        chk("t3_grant", grant, 3'b100);
        set_ch(0, 25'h40, 5'd0, 32'h5555, 4'h0);
        req_write = 3'b001;
        n_acc = 0;
        for (int c = 0; c < 16; c++) begin
            mem_wait = (c % 2 == 0);
            #1;
            chk("t3_locked", grant, 3'b100);
            chk("t3_ack", beat_ack, mem_wait ? 3'b000 : 3'b100);
            if (c == 1) begin
                chk("t3_wdata", mem_writedata, 32'hCAFE_F00D);
                chk("t3_byteen", mem_byteen_n, 4'b0101);
            end
            if (!mem_wait) begin
                exp_addr = 25'h1FF_FFFE + ADDR_W'(n_acc);
                chk("t3_addr", mem_address, exp_addr);
                n_acc++;
            end
            tick();
        end
        chk("t3_end_grant", grant, 0);
        chk("t3_end_write_n", mem_write_n, 1);
        mem_wait = 1'b0;
        tick();
        chk("t3_ch0_grant", grant, 3'b001);
        chk("t3_ch0_addr", mem_address, 25'h40);
        chk("t3_ch0_ack", beat_ack, 3'b001);
        req_write = '0;
        tick();
        chk("t3_ch0_blen0_one_beat", grant, 0);

        // Tag FIFO fills after 8 read beats with no returns; one return resumes issue.
        set_ch(1, 25'h200, 5'd16, 32'h0, 4'hF);
        req_read = 3'b010;
        tick();
        chk("t4_grant", grant, 3'b010);
        req_read = '0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("t4_ack", beat_ack, 3'b010);
            tick();
        end
        chk("t4_full_read_n", mem_read_n, 1);
        chk("t4_full_ack", beat_ack, 0);
        tick();
        chk("t4_full_hold", mem_read_n, 1);
        chk("t4_full_addr", mem_address, 25'h208);
        mem_rvalid = 1'b1;
        #1;
        chk("t4_pop_tag", rd_valid, 3'b010);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("t4_resume", mem_read_n, 0);
        chk("t4_resume_addr", mem_address, 25'h208);
        n_acc = 8; outst = 7; hits = 0; pops = 0;
        for (int c = 0; c < 100; c++) begin
            if (grant == '0 && outst == 0) break;
            mem_rvalid = (outst > 0);
            #1;
            if (beat_ack[1]) begin n_acc++; outst++; end
            if (mem_rvalid) begin
                outst--; pops++;
                if (rd_valid == 3'b010) hits++;
            end
            tick();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("t4_drained", (grant == '0 && outst == 0), 1);
        chk("t4_beats", n_acc, 16);
        chk("t4_tags", hits, pops);
        chk("t4_tag_err", tag_err, 0);

        // Interleaved ch0/ch1 reads with 3-cycle return latency.
        set_ch(0, 25'h600, 5'd2, 32'h0, 4'hF);
        set_ch(1, 25'h700, 5'd2, 32'h0, 4'hF);
        req_read = 3'b011;
        na = 0; nr = 0;
        pv[0] = 1'b0; pv[1] = 1'b0; pv[2] = 1'b0;
        for (int c = 0; c < 30; c++) begin
            mem_rvalid = pv[2]; mem_readdata = 32'h5000 + c;
            #1;
            if (beat_ack != '0) begin
                chk("t5_ack_order", beat_ack, (na < 4) ? t5_exp[na] : 3'b000);
                na++;
            end
            if (mem_rvalid) begin
                chk("t5_tag_order", rd_valid, (nr < 4) ? t5_exp[nr] : 3'b000);
                nr++;
            end
            if (grant[0]) req_read[0] = 1'b0;
            if (grant[1]) req_read[1] = 1'b0;
            newv = (beat_ack != '0);
            tick();
            pv[2] = pv[1]; pv[1] = pv[0]; pv[0] = newv;
        end
        mem_rvalid = 1'b0;
        #1;
        chk("t5_issued", na, 4);
        chk("t5_returned", nr, 4);
        chk("t5_tag_err", tag_err, 0);

        // Unexpected return sets a sticky error.
        mem_rvalid = 1'b1;
        #1;
        chk("t6_no_rd_valid", rd_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("t6_tag_err_set", tag_err, 1);
        tick();
        chk("t6_tag_err_sticky", tag_err, 1);

        // Asynchronous reset in the middle of a read burst.
        set_ch(1, 25'h800, 5'd8, 32'h0, 4'hF);
        req_read = 3'b010;
        tick();
        req_read = '0;
        tick(); tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("t7_grant", grant, 0);
        chk("t7_read_n", mem_read_n, 1);
        chk("t7_write_n", mem_write_n, 1);
        chk("t7_address", mem_address, 0);
        chk("t7_byteen_n", mem_byteen_n, 4'hF);
        chk("t7_tag_err", tag_err, 0);
        chk("t7_beat_ack", beat_ack, 0);
        @(negedge Clk) Reset_n = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        #1;
        chk("t7_fifo_cleared", rd_valid, 0);
        tick();
        mem_rvalid = 1'b0;
        #1;
        chk("t7_err_after_clear", tag_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
